// File: rtl/oki_rom_arbiter_pkg.sv
// Shared sound-memory definitions: address/data widths and arbiter FSM states.
package oki_rom_arbiter_pkg;

    localparam int unsigned ROM_ADDR_W = 18;
    localparam int unsigned MEM_ADDR_W = 25;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } arb_state_t;

endpackage

// File: rtl/oki_rom_cache.sv
// One-entry read cache for a single OKI sample ROM port.
module oki_rom_cache
    import oki_rom_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ROM_ADDR_W-1:0] lookup_addr,
    input  logic                  fill,
    input  logic [ROM_ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0]     fill_data,
    output logic                  hit,
    output logic [DATA_W-1:0]     dout
);

    logic [ROM_ADDR_W-1:0] tag;
    logic [DATA_W-1:0]     data;
    logic                  tag_valid;

    // Capture a completed memory read as the new cache entry
    always_ff @(posedge clock) begin
        if (reset) begin
            tag       <= '0;
            data      <= '0;
            tag_valid <= 1'b0;
        end else if (fill) begin
            tag       <= fill_tag;
            data      <= fill_data;
            tag_valid <= 1'b1;
        end
    end

    // Combinational hit compare against the requester's current address
    always_comb begin
        hit  = tag_valid && (tag == lookup_addr);
        dout = data;
    end

endmodule

// File: rtl/oki_rom_arbiter.sv
// Arbitrates two OKI sample-ROM ports onto one sound-memory read port,
// each port fronted by a one-entry cache.
module oki_rom_arbiter
    import oki_rom_arbiter_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] OKI0_BASE = 25'h0000000,
    parameter logic [MEM_ADDR_W-1:0] OKI1_BASE = 25'h0040000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ROM_ADDR_W-1:0] io_oki0_addr,
    output logic [DATA_W-1:0]     io_oki0_dout,
    output logic                  io_oki0_valid,
    input  logic [ROM_ADDR_W-1:0] io_oki1_addr,
    output logic [DATA_W-1:0]     io_oki1_dout,
    output logic                  io_oki1_valid,
    output logic                  io_mem_rd,
    output logic [MEM_ADDR_W-1:0] io_mem_addr,
    input  logic                  io_mem_wait_n,
    input  logic                  io_mem_valid,
    input  logic [DATA_W-1:0]     io_mem_dout
);

    arb_state_t            state_q, state_d;
    logic                  grant_q, grant_d;       // 0 = OKI 0, 1 = OKI 1
    logic                  last_win_q, last_win_d; // winner of the last contested grant
    logic [ROM_ADDR_W-1:0] addr_latch_q, addr_latch_d;
    logic                  mem_rd_d;
    logic [MEM_ADDR_W-1:0] mem_addr_d;
    logic                  fill, fill0, fill1;
    logic                  hit0, hit1;
    logic                  pend0, pend1;

    oki_rom_cache u_cache0 (
        .clock       (clock),
        .reset       (reset),
        .lookup_addr (io_oki0_addr),
        .fill        (fill0),
        .fill_tag    (addr_latch_q),
        .fill_data   (io_mem_dout),
        .hit         (hit0),
        .dout        (io_oki0_dout)
    );

    oki_rom_cache u_cache1 (
        .clock       (clock),
        .reset       (reset),
        .lookup_addr (io_oki1_addr),
        .fill        (fill1),
        .fill_tag    (addr_latch_q),
        .fill_data   (io_mem_dout),
        .hit         (hit1),
        .dout        (io_oki1_dout)
    );

    assign io_oki0_valid = hit0;
    assign io_oki1_valid = hit1;

    // State register plus the registered memory-port outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_win_q   <= 1'b1;
            addr_latch_q <= '0;
            io_mem_rd    <= 1'b0;
            io_mem_addr  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_win_q   <= last_win_d;
            addr_latch_q <= addr_latch_d;
            io_mem_rd    <= mem_rd_d;
            io_mem_addr  <= mem_addr_d;
        end
    end

    // Next-state, grant selection and address latch
    // The round-robin pointer only moves on contested grants, so a lone
    // uncontested fetch does not steal the other port's turn.
    always_comb begin
        pend0        = !hit0 && !((state_q != ST_IDLE) && !grant_q);
        pend1        = !hit1 && !((state_q != ST_IDLE) && grant_q);
        state_d      = state_q;
        grant_d      = grant_q;
        last_win_d   = last_win_q;
        addr_latch_d = addr_latch_q;
        case (state_q)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    state_d = ST_REQ;
                    if (pend0 && pend1) begin
                        grant_d    = !last_win_q;
                        last_win_d = !last_win_q;
                    end else begin
                        grant_d = pend1;
                    end
                    addr_latch_d = grant_d ? io_oki1_addr : io_oki0_addr;
                end
            end
            ST_REQ: begin
                if (io_mem_wait_n) begin
                    state_d = io_mem_valid ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cache fill strobes and next values of the memory-port registers
    always_comb begin
        fill  = ((state_q == ST_REQ) && io_mem_wait_n && io_mem_valid) ||
                ((state_q == ST_WAIT) && io_mem_valid);
        fill0 = fill && !grant_q;
        fill1 = fill && grant_q;
        mem_rd_d   = (state_d == ST_REQ);
        mem_addr_d = io_mem_addr;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            mem_addr_d = (grant_d ? OKI1_BASE : OKI0_BASE) +
                         {{(MEM_ADDR_W-ROM_ADDR_W){1'b0}}, addr_latch_d};
        end
    end

endmodule

// File: tb/tb_oki_rom_arbiter.sv
// Directed self-checking bench for oki_rom_arbiter.
module tb_oki_rom_arbiter;

    logic        clock;
    logic        reset;
    logic [17:0] io_oki0_addr;
    logic [7:0]  io_oki0_dout;
    logic        io_oki0_valid;
    logic [17:0] io_oki1_addr;
    logic [7:0]  io_oki1_dout;
    logic        io_oki1_valid;
    logic        io_mem_rd;
    logic [24:0] io_mem_addr;
    logic        io_mem_wait_n;
    logic        io_mem_valid;
    logic [7:0]  io_mem_dout;

    int checks = 0;
    int fails  = 0;

    oki_rom_arbiter #(
        .OKI0_BASE (25'h0000000),
        .OKI1_BASE (25'h0040000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_oki0_addr  (io_oki0_addr),
        .io_oki0_dout  (io_oki0_dout),
        .io_oki0_valid (io_oki0_valid),
        .io_oki1_addr  (io_oki1_addr),
        .io_oki1_dout  (io_oki1_dout),
        .io_oki1_valid (io_oki1_valid),
        .io_mem_rd     (io_mem_rd),
        .io_mem_addr   (io_mem_addr),
        .io_mem_wait_n (io_mem_wait_n),
        .io_mem_valid  (io_mem_valid),
        .io_mem_dout   (io_mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a read request, then accept it after `stall` cycles
    // and return `data` in the following cycle. Ends in the cycle after the fill.
    task automatic serve(input int stall, input logic [7:0] data,
                         output bit seen, output logic [24:0] addr,
                         output bit stable, output logic rd_wait);
        seen    = 1'b0;
        stable  = 1'b1;
        rd_wait = 1'b0;
        addr    = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (io_mem_rd === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) return;
        addr = io_mem_addr;
        io_mem_wait_n = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (io_mem_rd !== 1'b1 || io_mem_addr !== addr) stable = 1'b0;
        end
        io_mem_wait_n = 1'b1;
        tick();
        io_mem_wait_n = 1'b0;
        rd_wait = io_mem_rd;
        io_mem_valid = 1'b1;
        io_mem_dout  = data;
        tick();
        io_mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_oki0_addr  = 18'h00010;
        io_oki1_addr  = 18'h00020;
        io_mem_wait_n = 1'b0;
        io_mem_valid  = 1'b0;
        io_mem_dout   = 8'h00;
        tick();
        tick();
        checks++;
        if (io_mem_rd !== 1'b0 || io_mem_addr !== 25'h0) begin
            fails++;
            $display("FAIL reset_mem_port: rd=%b addr=%h expected rd=0 addr=0000000", io_mem_rd, io_mem_addr);
        end
        checks++;
        if (io_oki0_valid !== 1'b0 || io_oki1_valid !== 1'b0 ||
            io_oki0_dout !== 8'h00 || io_oki1_dout !== 8'h00) begin
            fails++;
            $display("FAIL reset_cache: v0=%b v1=%b d0=%h d1=%h expected all 0",
                     io_oki0_valid, io_oki1_valid, io_oki0_dout, io_oki1_dout);
        end
        reset = 1'b0;
        checks++;
        if (io_oki0_valid !== 1'b0 || io_oki1_valid !== 1'b0 || io_mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL after_reset: v0=%b v1=%b rd=%b expected 0 0 0",
                     io_oki0_valid, io_oki1_valid, io_mem_rd);
        end
    endtask

    task automatic test_basic();
        bit          seen, stable;
        logic [24:0] addr;
        logic        rd_wait;
        tick();
        checks++;
        if (io_mem_rd !== 1'b1 || io_mem_addr !== 25'h0000010) begin
            fails++;
            $display("FAIL basic_req_cycle1: rd=%b addr=%h expected rd=1 addr=0000010", io_mem_rd, io_mem_addr);
        end
        io_mem_wait_n = 1'b1;
        tick();
        io_mem_wait_n = 1'b0;
        checks++;
        if (io_mem_rd !== 1'b0 || io_oki0_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_wait_cycle2: rd=%b v0=%b expected rd=0 v0=0", io_mem_rd, io_oki0_valid);
        end
        io_mem_valid = 1'b1;
        io_mem_dout  = 8'hA5;
        tick();
        io_mem_valid = 1'b0;
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'hA5) begin
            fails++;
            $display("FAIL basic_fill_cycle3: v0=%b d0=%h expected v0=1 d0=a5", io_oki0_valid, io_oki0_dout);
        end
        serve(0, 8'h5A, seen, addr, stable, rd_wait);
        checks++;
        if (!seen || addr !== 25'h0040020) begin
            fails++;
            $display("FAIL oki1_mem_addr: seen=%b addr=%h expected seen=1 addr=0040020", seen, addr);
        end
        checks++;
        if (io_oki1_valid !== 1'b1 || io_oki1_dout !== 8'h5A ||
            io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'hA5) begin
            fails++;
            $display("FAIL oki1_fill_isolation: v1=%b d1=%h v0=%b d0=%h expected 1 5a 1 a5",
                     io_oki1_valid, io_oki1_dout, io_oki0_valid, io_oki0_dout);
        end
    endtask

    task automatic test_round_robin();
        bit          seen, stable;
        logic [24:0] addr;
        logic        rd_wait;
        io_oki0_addr = 18'h00030;
        io_oki1_addr = 18'h00031;
        serve(0, 8'h31, seen, addr, stable, rd_wait);
        checks++;
        if (!seen || addr !== 25'h0040031) begin
            fails++;
            $display("FAIL rr_first_oki1: seen=%b addr=%h expected seen=1 addr=0040031", seen, addr);
        end
        serve(0, 8'h30, seen, addr, stable, rd_wait);
        checks++;
        if (!seen || addr !== 25'h0000030) begin
            fails++;
            $display("FAIL rr_second_oki0: seen=%b addr=%h expected seen=1 addr=0000030", seen, addr);
        end
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'h30 ||
            io_oki1_valid !== 1'b1 || io_oki1_dout !== 8'h31) begin
            fails++;
            $display("FAIL rr_data: v0=%b d0=%h v1=%b d1=%h expected 1 30 1 31",
                     io_oki0_valid, io_oki0_dout, io_oki1_valid, io_oki1_dout);
        end
    endtask

    task automatic test_hit();
        int rd_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (io_mem_rd === 1'b1) rd_count++;
        end
        checks++;
        if (rd_count !== 0 || io_oki0_valid !== 1'b1) begin
            fails++;
            $display("FAIL hit_no_request: rd_cycles=%0d v0=%b expected 0 and 1", rd_count, io_oki0_valid);
        end
    endtask

    task automatic test_stall();
        bit          seen, stable;
        logic [24:0] addr;
        logic        rd_wait;
        io_oki0_addr = 18'h00044;
        serve(4, 8'h4D, seen, addr, stable, rd_wait);
        checks++;
        if (!seen || addr !== 25'h0000044 || !stable) begin
            fails++;
            $display("FAIL stall_hold: seen=%b addr=%h stable=%b expected 1 0000044 1", seen, addr, stable);
        end
        checks++;
        if (rd_wait !== 1'b0 || io_mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL stall_single_req: rd_in_wait=%b rd_after=%b expected 0 0", rd_wait, io_mem_rd);
        end
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'h4D) begin
            fails++;
            $display("FAIL stall_fill: v0=%b d0=%h expected 1 4d", io_oki0_valid, io_oki0_dout);
        end
    endtask

    task automatic test_fast_fill();
        bit seen = 1'b0;
        io_oki1_addr = 18'h00055;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (io_mem_rd === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || io_mem_addr !== 25'h0040055) begin
            fails++;
            $display("FAIL fast_req: seen=%b addr=%h expected 1 0040055", seen, io_mem_addr);
        end
        io_mem_wait_n = 1'b1;
        io_mem_valid  = 1'b1;
        io_mem_dout   = 8'hC3;
        tick();
        io_mem_wait_n = 1'b0;
        io_mem_valid  = 1'b0;
        checks++;
        if (io_oki1_valid !== 1'b1 || io_oki1_dout !== 8'hC3 || io_mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL fast_fill: v1=%b d1=%h rd=%b expected 1 c3 0", io_oki1_valid, io_oki1_dout, io_mem_rd);
        end
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'h4D) begin
            fails++;
            $display("FAIL fast_other_cache: v0=%b d0=%h expected 1 4d", io_oki0_valid, io_oki0_dout);
        end
    endtask

    task automatic test_addr_change();
        bit          seen = 1'b0;
        bit          stable;
        logic [24:0] addr;
        logic        rd_wait;
        io_oki0_addr = 18'h00100;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (io_mem_rd === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || io_mem_addr !== 25'h0000100) begin
            fails++;
            $display("FAIL chg_first_req: seen=%b addr=%h expected 1 0000100", seen, io_mem_addr);
        end
        io_mem_wait_n = 1'b1;
        tick();
        io_mem_wait_n = 1'b0;
        io_oki0_addr  = 18'h00101;
        io_mem_valid  = 1'b1;
        io_mem_dout   = 8'h11;
        tick();
        io_mem_valid = 1'b0;
        checks++;
        if (io_oki0_valid !== 1'b0) begin
            fails++;
            $display("FAIL chg_stale_valid: v0=%b expected 0", io_oki0_valid);
        end
        io_oki0_addr = 18'h00100;
        #1;
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'h11) begin
            fails++;
            $display("FAIL chg_fill_tag: v0=%b d0=%h expected 1 11", io_oki0_valid, io_oki0_dout);
        end
        io_oki0_addr = 18'h00101;
        #1;
        serve(0, 8'h22, seen, addr, stable, rd_wait);
        checks++;
        if (!seen || addr !== 25'h0000101) begin
            fails++;
            $display("FAIL chg_refetch: seen=%b addr=%h expected 1 0000101", seen, addr);
        end
        checks++;
        if (io_oki0_valid !== 1'b1 || io_oki0_dout !== 8'h22) begin
            fails++;
            $display("FAIL chg_refill: v0=%b d0=%h expected 1 22", io_oki0_valid, io_oki0_dout);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit seen = 1'b0;
        io_oki0_addr = 18'h00200;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (io_mem_rd === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || io_mem_addr !== 25'h0000200) begin
            fails++;
            $display("FAIL rst_mid_req: seen=%b addr=%h expected 1 0000200", seen, io_mem_addr);
        end
        io_mem_wait_n = 1'b1;
        tick();
        io_mem_wait_n = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        io_mem_valid = 1'b1;
        io_mem_dout  = 8'h77;
        checks++;
        if (io_oki0_valid !== 1'b0 || io_oki1_valid !== 1'b0 || io_mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_state: v0=%b v1=%b rd=%b expected 0 0 0",
                     io_oki0_valid, io_oki1_valid, io_mem_rd);
        end
        tick();
        io_mem_valid = 1'b0;
        checks++;
        if (io_oki0_valid !== 1'b0 || io_mem_rd !== 1'b1 || io_mem_addr !== 25'h0000200) begin
            fails++;
            $display("FAIL rst_mid_ignore: v0=%b rd=%b addr=%h expected 0 1 0000200",
                     io_oki0_valid, io_mem_rd, io_mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hit();
        test_stall();
        test_fast_fill();
        test_addr_change();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation reached 100000 time units without completing");
        $fatal(1);
    end

endmodule
